// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC generation, req/ack instruction memory port, fetch queue and registered IF/ID output
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag_i,
  input  logic [31:0] target_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [63:0] imem_data_i,
  output logic [31:0] id_pc_o,
  output logic [63:0] id_inst_o,
  output logic        id_valid_o
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] q_pc [DEPTH];
  logic [63:0] q_inst [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count, cnt_next;
  logic [31:0] fetch_pc, pend_target, tgt, base;
  logic drop, redirect_pending;
  logic ack, busy, empty, redirect, pop, flush, keep_req, late, push, issue, pend;
  // Per-edge decisions: handshake completion, queue push/pop/flush, redirect case and next request
  always_comb begin
    ack      = imem_req_o && imem_ack_i;
    busy     = imem_req_o && !imem_ack_i;
    empty    = count == '0;
    redirect = branch_flag_i && id_valid_o && !stall;
    pop      = !stall && !empty;
    flush    = redirect && !empty;
    keep_req = redirect && empty && imem_req_o && !drop;
    late     = redirect && empty && !(imem_req_o && !drop);
    push     = ack && !drop && !flush;
    cnt_next = flush ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
    issue    = !busy && cnt_next < (AW+1)'(DEPTH);
    pend     = late || (redirect_pending && !redirect);
    tgt      = late ? target_addr_i : pend_target;
    base     = (flush || keep_req) ? target_addr_i : fetch_pc;
  end
  // Queue payload storage; only the pointers and count need reset
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= imem_addr_o;
      q_inst[wr_ptr] <= imem_data_i;
    end
  end
  // Fetch PC, request handshake, queue pointers, redirect bookkeeping and IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc         <= RESET_PC;
      pend_target      <= '0;
      redirect_pending <= 1'b0;
      drop             <= 1'b0;
      imem_req_o       <= 1'b0;
      imem_addr_o      <= '0;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      id_pc_o          <= '0;
      id_inst_o        <= '0;
      id_valid_o       <= 1'b0;
    end else begin
      if (issue) begin
        imem_addr_o      <= base;
        fetch_pc         <= pend ? tgt : base + 32'd8;
        redirect_pending <= 1'b0;
      end else begin
        fetch_pc         <= base;
        redirect_pending <= pend;
      end
      pend_target <= tgt;
      imem_req_o  <= busy || issue;
      drop        <= ack ? 1'b0 : (drop || (flush && imem_req_o));
      rd_ptr      <= flush ? '0 : rd_ptr + AW'(pop);
      wr_ptr      <= flush ? '0 : wr_ptr + AW'(push);
      count       <= cnt_next;
      if (!stall) begin
        id_valid_o <= !empty;
        id_inst_o  <= empty ? '0 : q_inst[rd_ptr];
        id_pc_o    <= empty ? id_pc_o : q_pc[rd_ptr];
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a latency-configurable memory model
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, branch_flag_i = 1'b0;
  logic [31:0] target_addr_i = '0;
  logic imem_req_o, imem_ack_i, id_valid_o;
  logic [31:0] imem_addr_o, id_pc_o;
  logic [63:0] imem_data_i, id_inst_o;
  int lat = 0, wcnt = 0, checks = 0, errors = 0, bubbles = 0, b0;
  logic ack_en = 1'b1, ack_force = 1'b0, upd = 1'b0, pend = 1'b0;
  logic [31:0] paddr, e_pc, held;
  logic [31:0] exp_q[$], done_q[$];

  fetch_unit #(.RESET_PC(32'h100), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag_i(branch_flag_i),
    .target_addr_i(target_addr_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i), .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o), .id_valid_o(id_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] inst_of(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  assign imem_ack_i  = ack_force || (ack_en && imem_req_o && wcnt >= lat);
  assign imem_data_i = inst_of(imem_addr_o);

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wait_pc(input logic [31:0] pc);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(id_valid_o && id_pc_o == pc) && n < 500);
    check("wait_pc_reached", id_pc_o, pc);
  endtask

  task automatic reset_zero(input string tag);
    check({tag, "_req"}, imem_req_o, 0);
    check({tag, "_addr"}, imem_addr_o, 0);
    check({tag, "_pc"}, id_pc_o, 0);
    check({tag, "_inst"}, id_inst_o, 0);
    check({tag, "_valid"}, id_valid_o, 0);
  endtask

  always @(posedge clk) begin
    wcnt  <= (rst || !imem_req_o || imem_ack_i) ? 0 : wcnt + 1;
    upd   <= !stall && !rst;
    pend  <= !rst && imem_req_o && !imem_ack_i;
    paddr <= imem_addr_o;
    if (!rst && imem_req_o && imem_ack_i) done_q.push_back(imem_addr_o);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (pend) begin
        check("addr_hold", imem_addr_o, paddr);
        check("req_hold", imem_req_o, 1);
      end
      if (!id_valid_o) check("nop_inst", id_inst_o, 0);
      if (upd && !id_valid_o) bubbles++;
      if (upd && id_valid_o && exp_q.size() > 0) begin
        e_pc = exp_q.pop_front();
        check("id_pc", id_pc_o, e_pc);
        check("id_inst", id_inst_o, inst_of(e_pc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    for (int a = 32'h100; a <= 32'h200; a += 8) exp_q.push_back(32'(a));
    exp_q.push_back(32'h208);
    for (int a = 32'h400; a <= 32'h428; a += 8) exp_q.push_back(32'(a));
    for (int a = 32'h600; a <= 32'h618; a += 8) exp_q.push_back(32'(a));
    repeat (3) @(negedge clk);
    reset_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("first_req", imem_req_o, 1);
    check("first_addr", imem_addr_o, 32'h100);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("stream_valid", id_valid_o, 1);
      check("stream_pc", id_pc_o, 32'h100 + 32'(8 * i));
      @(negedge clk);
    end
    wait_pc(32'h120);
    stall = 1'b1;
    held = id_pc_o;
    repeat (3) begin
      @(negedge clk);
      check("stall_pc", id_pc_o, held);
      check("stall_valid", id_valid_o, 1);
    end
    check("full_no_req", imem_req_o, 0);
    stall = 1'b0;
    wait_pc(32'h140);
    lat = 3;
    b0 = bubbles;
    wait_pc(32'h170);
    check("slow_bubbles", bubbles > b0, 1);
    lat = 0;
    wait_pc(32'h1F8);
    stall = 1'b1;
    repeat (2) @(negedge clk);
    stall = 1'b0;
    ack_en = 1'b0;
    @(negedge clk);
    check("branch_pc", id_pc_o, 32'h200);
    branch_flag_i = 1'b1;
    target_addr_i = 32'h400;
    @(negedge clk);
    branch_flag_i = 1'b0;
    check("slot_pc", id_pc_o, 32'h208);
    check("drop_in_flight", imem_req_o, 1);
    check("drop_addr", imem_addr_o, 32'h218);
    ack_en = 1'b1;
    wait_pc(32'h408);
    lat = 3;
    wait_pc(32'h420);
    done_q.delete();
    branch_flag_i = 1'b1;
    target_addr_i = 32'h600;
    @(negedge clk);
    branch_flag_i = 1'b0;
    n = 0;
    while (done_q.size() < 2 && n < 200) begin @(negedge clk); n++; end
    check("slot_req_count", done_q.size() >= 2, 1);
    if (done_q.size() >= 2) begin
      check("slot_req", done_q[0], 32'h428);
      check("target_req", done_q[1], 32'h600);
    end
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin @(negedge clk); n++; end
    check("stream_drained", exp_q.size(), 0);
    n = 0;
    while (!(imem_req_o && !imem_ack_i) && n < 50) begin @(negedge clk); n++; end
    check("req_waiting", imem_req_o && !imem_ack_i, 1);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      reset_zero("midreq_reset");
    end
    for (int a = 32'h100; a <= 32'h118; a += 8) exp_q.push_back(32'(a));
    done_q.delete();
    rst = 1'b0;
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    check("restart_req", imem_req_o, 1);
    check("restart_addr", imem_addr_o, 32'h100);
    check("stray_ack_ignored", id_valid_o, 0);
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin @(negedge clk); n++; end
    check("restart_drained", exp_q.size(), 0);
    check("restart_first_done", done_q.size() > 0 ? done_q[0] : 32'hFFFF_FFFF, 32'h100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
